// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: bundle between the ID/EX pipeline register and the EX-stage
// multiply/divide unit.
//
// Handshake: the unit samples a new M-extension instruction only while it is
// idle. While stall_req=1 the ID/EX register must hold its contents. The
// result is valid for exactly the one cycle in which valid_o=1, and wreg_o
// rises with it. flush annuls whatever the unit is doing: no valid_o pulse
// follows.
//
// Signals:
//   ex_opcode/ex_funct/ex_m_sel  decoded instruction fields from ID/EX
//   ex_reg1/ex_reg2              rs1/rs2 operand values
//   ex_wd                        destination register index
//   flush                        annul the current EX instruction
//   stall_req                    hold PC/IF-ID/ID-EX this cycle
//   valid_o/result_o             completed result and its strobe
//   wd_o/wreg_o                  write-back destination and enable
interface ex_muldiv_if;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct;
  logic        ex_m_sel;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        flush;
  logic        stall_req;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  wd_o;
  logic        wreg_o;

  // Pipeline side (ID/EX register and hazard logic).
  modport master (
    output ex_opcode, ex_funct, ex_m_sel, ex_reg1, ex_reg2, ex_wd, flush,
    input  stall_req, valid_o, result_o, wd_o, wreg_o
  );

  // Execution unit side.
  modport slave (
    input  ex_opcode, ex_funct, ex_m_sel, ex_reg1, ex_reg2, ex_wd, flush,
    output stall_req, valid_o, result_o, wd_o, wreg_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in the EX stage.
//
// An R-type instruction with funct7[0]=1 seen in IDLE either resolves at once
// (divide by zero, signed overflow) or runs 32 iterations on unsigned operand
// magnitudes: MSB-first shift-add for multiplies, restoring shift-subtract for
// divides. Signs are reapplied in DONE, where the result is presented for one
// cycle.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        ex_muldiv_if.slave bundle (instruction in, result/stall out)
//   state_dbg  current FSM state (0=IDLE, 1=BUSY, 2=DONE)
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state, state_next;

  // Operation latched at start.
  logic [31:0]      a_mag, b_mag;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             special_q;
  logic [31:0]      spec_val_q;
  logic [4:0]       wd_q;
  logic [63:0]      acc;
  logic [CNT_W-1:0] cnt;

  // Values held after the DONE cycle.
  logic [31:0]      result_q;
  logic [4:0]       wd_out_q;

  // ---------------- start decode ----------------
  logic        start;
  logic        signed_a, signed_b, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic        neg_in;
  logic        div_zero, div_ovf, special;
  logic [31:0] spec_val;

  always_comb begin
    start    = (bus.ex_opcode == 7'b0110011) && bus.ex_m_sel;
    // MULHU, DIVU and REMU treat rs1 as unsigned; MULHSU also treats rs2 so.
    signed_a = !(bus.ex_funct == 3'b011 || bus.ex_funct == 3'b101 ||
                 bus.ex_funct == 3'b111);
    signed_b = signed_a && (bus.ex_funct != 3'b010);
    a_neg    = signed_a && bus.ex_reg1[31];
    b_neg    = signed_b && bus.ex_reg2[31];
    a_abs    = a_neg ? (~bus.ex_reg1 + 32'd1) : bus.ex_reg1;
    b_abs    = b_neg ? (~bus.ex_reg2 + 32'd1) : bus.ex_reg2;
    // Remainder follows the dividend; everything else is sign-xor.
    neg_in   = (bus.ex_funct[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);

    div_zero = bus.ex_funct[2] && (bus.ex_reg2 == 32'd0);
    div_ovf  = (bus.ex_funct == 3'b100 || bus.ex_funct == 3'b110) &&
               (bus.ex_reg1 == 32'h8000_0000) && (bus.ex_reg2 == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    spec_val = 32'd0;
    if (div_zero)     spec_val = bus.ex_funct[1] ? bus.ex_reg1 : 32'hFFFF_FFFF;
    else if (div_ovf) spec_val = bus.ex_funct[1] ? 32'd0 : 32'h8000_0000;
  end

  // ---------------- iteration datapath ----------------
  logic [4:0]  bit_idx;
  logic [63:0] mul_step;
  logic [32:0] rem_shift, diff;
  logic        ge;
  logic [63:0] div_step;

  always_comb begin
    // Both algorithms consume operand bits MSB first.
    bit_idx   = 5'(WIDTH - 1) - cnt[4:0];
    mul_step  = {acc[62:0], 1'b0} + (b_mag[bit_idx] ? {32'd0, a_mag} : 64'd0);
    // acc[63:32] is the partial remainder, acc[31:0] the quotient so far.
    rem_shift = {acc[63:32], a_mag[bit_idx]};
    diff      = rem_shift - {1'b0, b_mag};
    ge        = !diff[32];
    div_step  = {(ge ? diff[31:0] : rem_shift[31:0]), acc[30:0], ge};
  end

  // ---------------- sign fix-up and result select ----------------
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fixed;

  always_comb begin
    prod_fix = neg_q ? (~acc + 64'd1) : acc;
    quo_fix  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_q ? (~acc[63:32] + 32'd1) : acc[63:32];
    fixed    = 32'd0;
    if (special_q) begin
      fixed = spec_val_q;
    end else begin
      case (op_q)
        3'b000:                 fixed = prod_fix[31:0];
        3'b001, 3'b010, 3'b011: fixed = prod_fix[63:32];
        3'b100, 3'b101:         fixed = quo_fix;
        default:                fixed = rem_fix;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  logic done_live;

  always_comb begin
    state_next    = state;
    bus.stall_req = 1'b0;
    done_live     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !bus.flush) begin
          bus.stall_req = !rst;
          state_next    = special ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          bus.stall_req = !rst;
          if (cnt == LAST) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        done_live  = !bus.flush && !rst;
      end
      default: state_next = IDLE;
    endcase
    bus.valid_o  = done_live;
    bus.wreg_o   = done_live;
    bus.result_o = done_live ? fixed : result_q;
    bus.wd_o     = done_live ? wd_q : wd_out_q;
  end

  assign state_dbg = state;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_mag      <= '0;
      b_mag      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
      wd_q       <= '0;
      acc        <= '0;
      cnt        <= '0;
      result_q   <= '0;
      wd_out_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !bus.flush) begin
            a_mag      <= a_abs;
            b_mag      <= b_abs;
            op_q       <= bus.ex_funct;
            neg_q      <= neg_in;
            special_q  <= special;
            spec_val_q <= spec_val;
            wd_q       <= bus.ex_wd;
            acc        <= '0;
            cnt        <= '0;
          end
        end
        BUSY: begin
          if (!bus.flush) begin
            acc <= op_q[2] ? div_step : mul_step;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt <= '0;
          if (!bus.flush) begin
            result_q <= fixed;
            wd_out_q <= wd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv. Expected {wd, result} pairs
// are queued when an instruction is driven and popped when valid_o fires.
module tb_ex_muldiv;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  ex_muldiv_if bus();

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    up = {32'd0, a} * {32'd0, b};
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: return up[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(bus.valid_o), 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_result", 64'(bus.result_o), 64'(exp_e[31:0]));
        check("sb_wd", 64'(bus.wd_o), 64'(exp_e[36:32]));
        check("sb_wreg", 64'(bus.wreg_o), 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.ex_opcode = 7'd0;
    bus.ex_funct  = 3'd0;
    bus.ex_m_sel  = 1'b0;
    bus.ex_reg1   = 32'd0;
    bus.ex_reg2   = 32'd0;
    bus.ex_wd     = 5'd0;
    bus.flush     = 1'b0;
  endtask

  task automatic drive_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd);
    bus.ex_opcode = 7'b0110011;
    bus.ex_funct  = f;
    bus.ex_m_sel  = 1'b1;
    bus.ex_reg1   = a;
    bus.ex_reg2   = b;
    bus.ex_wd     = wd;
    bus.flush     = 1'b0;
  endtask

  // Called at posedge+1 with the unit idle; returns at posedge+1 after DONE.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd,
                        input logic [31:0] exp, input int exp_stall, input bit hold_after);
    int stalls = 0;
    int cyc    = 0;
    bit done   = 1'b0;
    drive_op(f, a, b, wd);
    exp_q.push_back({wd, exp});
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.stall_req) stalls++;
      if (bus.valid_o) begin
        done = 1'b1;
        check({tag, "_stall_in_done"}, 64'(bus.stall_req), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_stall + 1));
    if (!hold_after) begin
      drive_idle();
      @(negedge clk);
      check({tag, "_valid_drop"}, 64'(bus.valid_o), 64'd0);
      check({tag, "_result_hold"}, 64'(bus.result_o), 64'(exp));
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          stall_seen, valid_seen;

    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(bus.stall_req), 64'd0);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_wd", 64'(bus.wd_o), 64'd0);
    check("rst_wreg", 64'(bus.wreg_o), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed multiplies and divides.
    run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33, 1'b0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulh",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 33, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33, 1'b0);
    run_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu",   3'b101, 32'd100,        32'd7,         5'd9,  32'd14,        33, 1'b0);
    run_op("remu",   3'b111, 32'd100,        32'd7,         5'd10, 32'd2,         33, 1'b0);

    // Special cases: one stall cycle.
    run_op("divu_z", 3'b101, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("rem_z",  3'b110, 32'd5,          32'd0,         5'd12, 32'd5,         1, 1'b0);
    run_op("div_ov", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ov", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         1, 1'b0);

    // Flush during BUSY cycle 10; the ID/EX slot is cleared alongside.
    drive_op(3'b000, 32'd123, 32'd456, 5'd15);
    repeat (10) @(posedge clk);
    #1;
    drive_idle();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(bus.stall_req), 64'd0);
    check("flush_valid", 64'(bus.valid_o), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_state", 64'(state_dbg), 64'd0);
    check("flush_stall_after", 64'(bus.stall_req), 64'd0);
    @(posedge clk);
    #1;
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd16, 32'd12, 33, 1'b0);

    // Reset in the middle of BUSY.
    drive_op(3'b101, 32'd1000, 32'd3, 5'd17);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    check("midrst_stall", 64'(bus.stall_req), 64'd0);
    check("midrst_valid", 64'(bus.valid_o), 64'd0);
    check("midrst_result", 64'(bus.result_o), 64'd0);
    check("midrst_wd", 64'(bus.wd_o), 64'd0);
    check("midrst_wreg", 64'(bus.wreg_o), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1;

    // Plain R-type op: never handled here.
    drive_op(3'b000, 32'd9, 32'd9, 5'd18);
    bus.ex_m_sel = 1'b0;
    stall_seen = 0;
    valid_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.stall_req) stall_seen++;
      if (bus.valid_o) valid_seen++;
    end
    check("nonm_stall", 64'(stall_seen), 64'd0);
    check("nonm_valid", 64'(valid_seen), 64'd0);
    @(posedge clk);
    #1;
    drive_idle();

    // Back-to-back DIVU: second starts right after the first DONE.
    run_op("b2b_1", 3'b101, 32'd1000,        32'd7,  5'd19, 32'd142,      33, 1'b1);
    run_op("b2b_2", 3'b101, 32'hFFFF_FFF0,   32'd16, 5'd20, 32'h0FFF_FFFF, 33, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      run_op("rand", rf, ra, rb, 5'($urandom_range(1, 31)), ref_op(rf, ra, rb),
             is_special(rf, ra, rb) ? 1 : 33, 1'b0);
    end

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- EX-stage consumer of the ID/EX pipeline bundle: reads the registered instruction fields and executes RV32M multiply/divide ops iteratively.
- Raises a stall request back to the ID/EX register and earlier stages until the result is ready.
- Sits beside the single-cycle ALU; the EX write-back mux selects its result when valid_o=1.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- ex_opcode  input  7  registered opcode from ID/EX
- ex_funct  input  3  registered funct3 from ID/EX
- ex_m_sel  input  1  funct7[0] from ID/EX; 1 selects M-extension
- ex_reg1  input  32  rs1 value
- ex_reg2  input  32  rs2 value
- ex_wd  input  5  destination register
- flush  input  1  annul current EX instruction (branch/exception)
- stall_req  output  1  hold PC/IF-ID/ID-EX this cycle
- valid_o  output  1  result valid this cycle
- result_o  output  32  M-op result
- wd_o  output  5  destination of completed op
- wreg_o  output  1  write-enable for completed op

Behaviour:
- Reset is synchronous, active-high (rst), on clock clk; rst dominates flush and all state.
- Reset values: state=IDLE, stall_req=0, valid_o=0, result_o=0, wd_o=0, wreg_o=0, counter=0.
- Start condition (IDLE only): ex_opcode=7'b0110011 and ex_m_sel=1.
- funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- stall_req is combinational: 1 when (IDLE and start and no flush) or state=BUSY; 0 in DONE and otherwise.
- IDLE:
  - Start with a special case (see below) -> precompute result, go DONE.
  - Other start -> latch operand magnitudes, result sign, op and wd; clear the 64-bit accumulator; counter=0; go BUSY.
  - No start -> stay IDLE.
- BUSY:
  - One iteration per cycle: shift-add for multiply, restoring shift-subtract for divide, on unsigned magnitudes.
  - counter increments each cycle; after iteration WIDTH-1, go DONE.
  - BUSY lasts exactly 32 cycles.
- DONE:
  - Apply sign fix-up (two's-complement negate when the result sign is negative) and select the result half.
  - For exactly one cycle: valid_o=1, wreg_o=1, result_o and wd_o driven; stall_req=0.
  - Next state IDLE. Inputs still show the same instruction this cycle; a start is never sampled in DONE.
  - result_o holds its value afterwards; valid_o and wreg_o return to 0.
- Latency:
  - Normal op: start cycle + 32 BUSY + 1 DONE = 34 cycles in EX; stall_req high 33 cycles.
  - Special case: 2 cycles in EX; stall_req high 1 cycle.
- Sign rules:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - MUL returns the low 32 bits; MULH* return the high 32 bits.
  - Quotient is negative iff operand signs differ; remainder takes the dividend's sign.
- Special cases (resolved in IDLE, no iteration):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Flush:
  - In any non-reset state: next state IDLE, no valid_o/wreg_o pulse, stall_req=0 in the flush cycle.
  - Flush and start in the same IDLE cycle: no start.
- Reset mid-operation: BUSY/DONE abort to IDLE with no valid pulse.
- The ID/EX register must implement hold on stall_req; this block never reads ex_* inputs after the start cycle.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> stall 33 cycles; DONE: result_o=0xFFFFFFEB, wreg_o=1, wd_o=ex_wd, valid for one cycle.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with stall_req high exactly 1 cycle:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Flush in BUSY cycle 10 -> IDLE next cycle, stall_req=0, no valid pulse. A following MUL 3×4 -> 12 with normal latency.
- rst asserted in BUSY -> all outputs 0 next cycle.
- Non-M op (opcode 0110011, ex_m_sel=0) -> stall_req never asserts; valid_o stays 0.
- Back-to-back DIVU ops -> second starts the cycle after DONE; both results correct.
